// File: rtl/rst_sync_seq.sv
// Reset synchronizer and release sequencer: asserts NUM_RST active-low resets
// asynchronously, then releases them one by one on rsync_clk with soft-reset and test bypass.
module rst_sync_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_RST     = 2,
    parameter int RELEASE_GAP = 4,
    parameter int SOFT_LEN    = 8
) (
    input  logic               rsync_clk,
    input  logic               rst_n,
    input  logic               test_mode_in,
    input  logic               soft_rst_in,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               rst_done_out,
    output logic               rst_cause_out
);

    localparam int MAX_CNT = (RELEASE_GAP > SOFT_LEN) ? RELEASE_GAP : SOFT_LEN;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IW      = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    if (SYNC_STAGES < 2 || NUM_RST < 1 || RELEASE_GAP < 1 || SOFT_LEN < 1) begin : g_param_check
        $error("rst_sync_seq: parameter below its minimum");
    end

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SEQ  = 2'd1,
        DONE = 2'd2,
        SOFT = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               sync_ok;
    logic               sync_rising;
    logic               soft_q;
    logic [CW-1:0]      cnt, cnt_d;
    logic [IW-1:0]      idx, idx_d;
    logic [NUM_RST-1:0] rel_q, rel_d;
    logic               done_q, done_d;
    logic               cause_q, cause_d;

    assign sync_ok = sync_q[SYNC_STAGES-1];
    // Leave HOLD on the edge that raises sync_ok so the first release lands at SYNC_STAGES+RELEASE_GAP.
    assign sync_rising = sync_q[SYNC_STAGES-2] | sync_ok;

    always_ff @(posedge rsync_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            soft_q  <= 1'b0;
            state   <= HOLD;
            cnt     <= '0;
            idx     <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            soft_q  <= soft_rst_in & ~test_mode_in & (state != HOLD);
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        rel_d   = rel_q;
        done_d  = done_q;
        cause_d = cause_q;
        case (state)
            HOLD: begin
                rel_d  = '0;
                done_d = 1'b0;
                if (sync_rising) begin
                    state_d = SEQ;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            SEQ, DONE: begin
                if (soft_q) begin
                    state_d = SOFT;
                    cnt_d   = '0;
                    rel_d   = '0;
                    done_d  = 1'b0;
                    cause_d = 1'b1;
                end else if (state == SEQ) begin
                    if (cnt == CW'(RELEASE_GAP - 1)) begin
                        cnt_d = '0;
                        for (int k = 0; k < NUM_RST; k++) begin
                            if (idx == IW'(k)) rel_d[k] = 1'b1;
                        end
                        if (idx == IW'(NUM_RST - 1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            SOFT: begin
                rel_d  = '0;
                done_d = 1'b0;
                if (soft_q) begin
                    cnt_d = '0;
                end else if (cnt == CW'(SOFT_LEN - 1)) begin
                    state_d = SEQ;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = HOLD;
        endcase
    end

    assign rst_n_out     = test_mode_in ? {NUM_RST{rst_n}} : rel_q;
    assign rst_done_out  = test_mode_in ? rst_n : done_q;
    assign rst_cause_out = cause_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: a default instance and a 4-output instance, checked every edge
// against release times computed from edge arithmetic.
module tb_rst_sync_seq;

    localparam int A_SYNC = 2, A_N = 2, A_GAP = 4, A_SOFT = 8;
    localparam int B_SYNC = 3, B_N = 4, B_GAP = 1, B_SOFT = 8;

    logic       clk = 1'b0;
    logic       rst_n, test_mode, soft_a, soft_b;
    logic [1:0] out_a;
    logic       done_a, cause_a;
    logic [3:0] out_b;
    logic       done_b, cause_b;

    int n_tests = 0, n_fail = 0;
    int e, base_a, base_b, pend_edge, pend_base;
    logic m_cause;
    int s, r, rr, g;

    always #5 clk = ~clk;

    rst_sync_seq #(.SYNC_STAGES(A_SYNC), .NUM_RST(A_N), .RELEASE_GAP(A_GAP), .SOFT_LEN(A_SOFT)) dut_a (
        .rsync_clk(clk), .rst_n(rst_n), .test_mode_in(test_mode), .soft_rst_in(soft_a),
        .rst_n_out(out_a), .rst_done_out(done_a), .rst_cause_out(cause_a));

    rst_sync_seq #(.SYNC_STAGES(B_SYNC), .NUM_RST(B_N), .RELEASE_GAP(B_GAP), .SOFT_LEN(B_SOFT)) dut_b (
        .rsync_clk(clk), .rst_n(rst_n), .test_mode_in(test_mode), .soft_rst_in(soft_b),
        .rst_n_out(out_b), .rst_done_out(done_b), .rst_cause_out(cause_b));

    // Bit k is released once edge count reaches base + gap*(k+1).
    function automatic logic [3:0] rel_bits(int ed, int base, int gap, int n);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < n; k++) begin
            if (ed >= base + gap * (k + 1)) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp_v);
        end
    endtask

    task automatic check_all();
        logic [3:0] ea, eb;
        logic da, db;
        if (!rst_n) begin
            ea = '0; eb = '0; da = 1'b0; db = 1'b0;
        end else if (test_mode) begin
            ea = 4'b0011; eb = 4'b1111; da = 1'b1; db = 1'b1;
        end else begin
            ea = rel_bits(e, base_a, A_GAP, A_N);
            eb = rel_bits(e, base_b, B_GAP, B_N);
            da = (e >= base_a + A_GAP * A_N);
            db = (e >= base_b + B_GAP * B_N);
        end
        check("out_a",   {2'b00, out_a},   ea);
        check("done_a",  {3'b000, done_a}, {3'b000, da});
        check("cause_a", {3'b000, cause_a}, {3'b000, m_cause});
        check("out_b",   out_b,            eb);
        check("done_b",  {3'b000, done_b}, {3'b000, db});
        check("cause_b", {3'b000, cause_b}, 4'b0000);
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
        if (e == pend_edge) begin
            base_a  = pend_base;
            m_cause = 1'b1;
        end
        #1;
        check_all();
    endtask

    task automatic release_rst();
        rst_n     = 1'b1;
        e         = 0;
        base_a    = A_SYNC;
        base_b    = B_SYNC;
        pend_edge = -1;
    endtask

    task automatic async_drop();
        #2;
        rst_n   = 1'b0;
        m_cause = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b1; test_mode = 1'b0; soft_a = 1'b0; soft_b = 1'b0;
        e = 0; base_a = A_SYNC; base_b = B_SYNC; pend_edge = -1; pend_base = 0; m_cause = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) tick();

        // Power-on release sequence.
        release_rst();
        repeat (14) tick();

        // Soft reset from DONE, then re-pulsed while holding.
        s = 14 + $urandom_range(1, 6);
        while (e < s - 1) tick();
        soft_a = 1'b1;
        tick();
        soft_a    = 1'b0;
        pend_edge = s + 1;
        pend_base = s + 1 + A_SOFT;
        rr = s + 1 + $urandom_range(1, 6);
        while (e < rr - 1) tick();
        soft_a = 1'b1;
        tick();
        soft_a    = 1'b0;
        pend_edge = rr + 1;
        pend_base = rr + 1 + A_SOFT;
        repeat (A_SOFT + A_GAP * A_N + 3) tick();

        // Chip reset clears outputs and the sticky cause without a clock edge.
        async_drop();
        repeat (2) tick();

        // Glitch during SEQ.
        release_rst();
        g = $urandom_range(7, 9);
        while (e < g) tick();
        async_drop();
        repeat (2) tick();

        // Release shorter than the synchronizer depth produces no releases.
        release_rst();
        tick();
        rst_n = 1'b0;
        repeat (3) tick();

        release_rst();
        repeat (12) tick();

        // Test-mode bypass: outputs follow rst_n, soft reset ignored, FSM keeps running.
        test_mode = 1'b1;
        #1 check_all();
        #1 rst_n = 1'b0;
        #1 check_all();
        tick();
        release_rst();
        #1 check_all();
        r = $urandom_range(3, 4);
        while (e < r - 1) tick();
        soft_a = 1'b1;
        tick();
        soft_a = 1'b0;
        tick();
        test_mode = 1'b0;
        #1 check_all();
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_sync_seq.md
# rst_sync_seq

Parametrised reset synchronizer and release sequencer for the audioport `mclk` domain. It takes the asynchronous chip reset `rst_n` and produces `NUM_RST` synchronized, active-low reset outputs on `rsync_clk`. Each output asserts asynchronously and releases synchronously, one at a time, in a fixed order with a programmable gap between releases. It also supports a synchronous soft-reset request and a test-mode bypass, and is the next-generation replacement for the single-output two-flop reset synchronizer in the CDC path.

## Interface
Parameters:
- SYNC_STAGES, 2: depth of the synchronizer chain; must be at least 2.
- NUM_RST, 2: number of sequenced reset outputs; must be at least 1.
- RELEASE_GAP, 4: `rsync_clk` cycles between successive releases; must be at least 1.
- SOFT_LEN, 8: `rsync_clk` cycles that the outputs are held low after a soft reset; must be at least 1.
- Any parameter below its minimum causes an elaboration-time error.

Ports:
- rsync_clk  in  1  block clock. The surrounding test mux supplies it (`~mclk` in normal mode, `clk` in test mode).
- rst_n  in  1  reset, asynchronous, active-low.
- test_mode_in  in  1  scan/test bypass select. Quasi-static.
- soft_rst_in  in  1  soft-reset request, synchronous to `rsync_clk`, level-sampled.
- rst_n_out  out  NUM_RST  sequenced active-low resets. Bit 0 releases first.
- rst_done_out  out  1  high when all outputs are released.
- rst_cause_out  out  1  0 means the last reset was `rst_n`; 1 means it was a soft reset.

## Operation
All flops reset asynchronously on `rst_n` low. While `rst_n` is low:
- The synchronizer chain is all 0.
- FSM is in HOLD; counter and release index are 0.
- `rst_n_out` is all 0, `rst_done_out` is 0 and `rst_cause_out` is 0.

Synchronizer:
- A chain of SYNC_STAGES flops with a constant 1 at its input.
- `sync_ok` is the last stage of the chain.

FSM states: HOLD, SEQ, DONE, SOFT.
- HOLD: outputs all low. Move to SEQ when `sync_ok` is 1; on entry, counter = 0 and index = 0.
- SEQ: the counter increments every cycle. When counter = RELEASE_GAP-1:
  - set `rst_n_out[index]` to 1, clear the counter and increment the index;
  - if index = NUM_RST-1, go to DONE and set `rst_done_out` on the same edge.
- DONE: all outputs are 1; stay here until a soft reset.
- SOFT: all outputs are 0 and `rst_done_out` is 0. The counter counts SOFT_LEN cycles, then the FSM goes to SEQ with counter = 0 and index = 0. It does not re-enter HOLD, and the synchronizer chain is not cleared.

Soft reset:
- `soft_rst_in` = 1, sampled in SEQ or DONE (test mode off): on the next edge all `rst_n_out` bits go to 0, `rst_done_out` goes to 0, `rst_cause_out` goes to 1, and the FSM enters SOFT with counter = 0.
- `soft_rst_in` = 1 while in SOFT: the hold counter restarts at 0, which extends the hold.
- `soft_rst_in` is ignored in HOLD.
- `rst_cause_out` is sticky; only `rst_n` clears it.

Test mode (`test_mode_in` = 1):
- Every `rst_n_out` bit and `rst_done_out` equal `rst_n` combinationally.
- `soft_rst_in` is ignored.
- The FSM keeps running internally, so leaving test mode shows the current FSM outputs.

Arithmetic:
- Counter width is $clog2(max(RELEASE_GAP, SOFT_LEN)).
- Index width is $clog2(NUM_RST), with a minimum of 1.
- Neither the counter nor the index wraps past its terminal value.

## Timing
Edge numbering: edge 1 is the first `rsync_clk` rising edge after `rst_n` rises.
- `sync_ok` goes high at edge SYNC_STAGES.
- `rst_n_out[k]` goes high at edge SYNC_STAGES + RELEASE_GAP·(k+1).
- `rst_done_out` goes high on the same edge as `rst_n_out[NUM_RST-1]`.

With defaults:
- `rst_n_out[0]` goes high at edge 6.
- `rst_n_out[1]` and `rst_done_out` go high at edge 10.

Assertion:
- `rst_n` falling clears every output asynchronously, with zero clock latency, in any state.
- Soft-reset assertion takes effect one edge after `soft_rst_in` is sampled high.

Soft-reset release:
- With `soft_rst_in` sampled at edge S, outputs go low at S+1.
- `rst_n_out[k]` goes high at S+1+SOFT_LEN+RELEASE_GAP·(k+1).

Mid-operation events:
- `rst_n` glitch low during SEQ or SOFT: immediate return to HOLD, and the full sequence restarts from the synchronizer.
- `rst_n` released less than SYNC_STAGES edges before falling again: no output releases.

## Test plan
- Defaults; release `rst_n` -> `rst_n_out` = 00 until edge 6, 01 from edge 6, 11 and `rst_done_out` = 1 at edge 10, `rst_cause_out` = 0.
- NUM_RST = 4, RELEASE_GAP = 1, SYNC_STAGES = 3 -> bits release at edges 4, 5, 6, 7; done at edge 7.
- Defaults, in DONE, one-cycle `soft_rst_in` at edge 20 -> outputs 00 and done 0 at edge 21, `rst_cause_out` = 1, `rst_n_out[0]` high at edge 33, `rst_n_out[1]` high at edge 37.
- `soft_rst_in` re-pulsed at edge 25 during SOFT -> release restarts, `rst_n_out[0]` high at edge 38; a `rst_n` pulse low then clears `rst_cause_out` to 0.
- `rst_n` driven low at edge 8 during SEQ -> `rst_n_out[0]` drops immediately with no clock edge; after re-release, timing matches scenario 1.
- `test_mode_in` = 1 -> `rst_n_out` = 11 and `rst_done_out` follow `rst_n` combinationally; `soft_rst_in` high has no effect.
